// File: rtl/frame_align_ctrl_pkg.sv
// Shared constants for the ADC frame-line alignment supervisor: expected frame
// pattern, FSM state encoding and status counter widths.
package frame_align_ctrl_pkg;

  localparam logic [5:0] FRAME = 6'b111000;

  localparam int SLIP_W = 4;
  localparam int LOSS_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SEARCH = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;
  localparam state_t ST_FAIL   = 2'd3;

endpackage

// File: rtl/frame_run_cnt.sv
// Saturating consecutive-event counter. A cycle without the event (or while
// disabled) restarts the run; 'reached' flags the cycle whose event completes THRESH.
module frame_run_cnt #(
  parameter int THRESH = 64,
  localparam int W = $clog2(THRESH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic hit,
  output logic reached
);

  localparam logic [W-1:0] LAST = W'(THRESH - 1);
  localparam logic [W-1:0] TOP  = W'(THRESH);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (!clr && en && hit) begin
      cnt_d = (cnt_q == TOP) ? TOP : cnt_q + W'(1);
    end
  end

  // Combinational so the owner can act on the same edge that samples the final event.
  assign reached = !clr && en && hit && (cnt_q >= LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_align_ctrl.sv
// Frame-line alignment supervisor for one ADC chip: gates bitslip, counts slips,
// declares lock after a run of good frames, tracks lock loss and slip exhaustion.
module frame_align_ctrl
  import frame_align_ctrl_pkg::*;
#(
  parameter int GOOD_CNT  = 64,
  parameter int BAD_CNT   = 4,
  parameter int MAX_SLIPS = 12,
  parameter int RETRY_DLY = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [5:0]        DATA,
  input  logic              BS,
  output logic              BSENB,
  output logic              LOCKED,
  output logic              ERR,
  output logic [SLIP_W-1:0] SLIPCNT,
  output logic [LOSS_W-1:0] LOSSCNT
);

  localparam int                TMR_W    = $clog2(RETRY_DLY + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(RETRY_DLY - 1);
  localparam logic [SLIP_W-1:0] SLIP_MAX = SLIP_W'(MAX_SLIPS);
  localparam logic [SLIP_W-1:0] SLIP_SAT = '1;
  localparam logic [LOSS_W-1:0] LOSS_SAT = '1;

  state_t            state_q, state_d;
  logic              bsenb_q, bsenb_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [SLIP_W-1:0] slip_q, slip_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic              frame_ok;
  logic              in_search, in_locked, in_fail;
  logic [SLIP_W-1:0] slip_inc;
  logic              slip_hit, slip_exhaust, retry_done;
  logic              good_reached, bad_reached;

  assign frame_ok  = (DATA == FRAME);
  assign in_search = (state_q == ST_SEARCH);
  assign in_locked = (state_q == ST_LOCKED);
  assign in_fail   = (state_q == ST_FAIL);

  assign slip_inc     = (slip_q == SLIP_SAT) ? slip_q : slip_q + SLIP_W'(1);
  assign slip_hit     = in_search && BS;
  assign slip_exhaust = slip_hit && (slip_inc == SLIP_MAX);
  assign retry_done   = in_fail && (tmr_q == TMR_LAST);

  // A slip in the same cycle as a matching sample still breaks the good run.
  frame_run_cnt #(.THRESH(GOOD_CNT)) u_good_run (
    .clk     (CLK),
    .rst     (RST),
    .clr     (START),
    .en      (in_search),
    .hit     (frame_ok && !BS),
    .reached (good_reached)
  );

  frame_run_cnt #(.THRESH(BAD_CNT)) u_bad_run (
    .clk     (CLK),
    .rst     (RST),
    .clr     (START),
    .en      (in_locked),
    .hit     (!frame_ok),
    .reached (bad_reached)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      bsenb_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      slip_q   <= '0;
      loss_q   <= '0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      bsenb_q  <= bsenb_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      slip_q   <= slip_d;
      loss_q   <= loss_d;
      tmr_q    <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (START) begin
      state_d = ST_SEARCH;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_SEARCH: begin
          if (slip_exhaust) begin
            state_d = ST_FAIL;
          end else if (good_reached) begin
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: if (bad_reached) state_d = ST_SEARCH;
        ST_FAIL:   if (retry_done) state_d = ST_SEARCH;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs follow the next state so they change on the same edge as the FSM.
  always_comb begin
    bsenb_d  = (state_d == ST_SEARCH);
    locked_d = (state_d == ST_LOCKED);
    err_d    = err_q;
    slip_d   = slip_q;
    loss_d   = loss_q;
    tmr_d    = '0;
    if (START) begin
      err_d  = 1'b0;
      slip_d = '0;
    end else begin
      if (slip_hit) begin
        slip_d = slip_inc;
      end
      if (slip_exhaust) begin
        err_d = 1'b1;
      end
      if (in_locked && bad_reached) begin
        slip_d = '0;
        loss_d = (loss_q == LOSS_SAT) ? loss_q : loss_q + LOSS_W'(1);
      end
      if (retry_done) begin
        slip_d = '0;
      end
      if (in_fail && !retry_done) begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end
  end

  assign BSENB   = bsenb_q;
  assign LOCKED  = locked_q;
  assign ERR     = err_q;
  assign SLIPCNT = slip_q;
  assign LOSSCNT = loss_q;

endmodule

// File: tb/tb_frame_align_ctrl.sv
// Bench for frame_align_ctrl: directed scenarios plus a randomized soak, each cycle
// compared against a rule-level model of the alignment behaviour.
module tb_frame_align_ctrl;

  localparam logic [5:0] FRAME_PAT = 6'b111000;
  localparam int GOOD  = 64;
  localparam int BAD   = 4;
  localparam int SLIPS = 12;
  localparam int RETRY = 1024;

  localparam int MD_IDLE   = 0;
  localparam int MD_SEARCH = 1;
  localparam int MD_LOCK   = 2;
  localparam int MD_FAIL   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] data = '0;
  logic       bs = 1'b0;
  logic       bsenb, locked, err;
  logic [3:0] slipcnt;
  logic [7:0] losscnt;

  int checks = 0;
  int failures = 0;

  int m_mode, m_good, m_bad, m_slips, m_loss, m_wait;
  bit m_err;

  frame_align_ctrl dut (
    .CLK     (clk),
    .RST     (rst),
    .START   (start),
    .DATA    (data),
    .BS      (bs),
    .BSENB   (bsenb),
    .LOCKED  (locked),
    .ERR     (err),
    .SLIPCNT (slipcnt),
    .LOSSCNT (losscnt)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] rol6(input logic [5:0] v);
    return {v[4:0], v[5]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MD_IDLE; m_good = 0; m_bad = 0; m_slips = 0;
    m_loss = 0; m_wait = 0; m_err = 0;
  endtask

  // One clock of the alignment rules, applied to the inputs seen at the edge.
  task automatic model_step(input bit st, input logic [5:0] d, input bit b);
    bit match;
    match = (d == FRAME_PAT);
    if (st) begin
      m_mode = MD_SEARCH; m_slips = 0; m_err = 0; m_good = 0; m_bad = 0; m_wait = 0;
    end else if (m_mode == MD_SEARCH) begin
      if (b) begin
        m_good = 0;
        if (m_slips < 15) m_slips++;
        if (m_slips == SLIPS) begin
          m_mode = MD_FAIL; m_err = 1; m_wait = 0;
        end
      end else if (match) begin
        m_good++;
        if (m_good == GOOD) begin
          m_mode = MD_LOCK; m_good = 0; m_bad = 0;
        end
      end else begin
        m_good = 0;
      end
    end else if (m_mode == MD_LOCK) begin
      if (!match) begin
        m_bad++;
        if (m_bad == BAD) begin
          m_mode = MD_SEARCH; m_bad = 0; m_good = 0; m_slips = 0;
          if (m_loss < 255) m_loss++;
        end
      end else begin
        m_bad = 0;
      end
    end else if (m_mode == MD_FAIL) begin
      m_wait++;
      if (m_wait == RETRY) begin
        m_mode = MD_SEARCH; m_slips = 0; m_good = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("cyc_bsenb",   32'(bsenb),   32'(m_mode == MD_SEARCH));
    chk("cyc_locked",  32'(locked),  32'(m_mode == MD_LOCK));
    chk("cyc_err",     32'(err),     32'(m_err));
    chk("cyc_slipcnt", 32'(slipcnt), 32'(m_slips));
    chk("cyc_losscnt", 32'(losscnt), 32'(m_loss));
  endtask

  task automatic cyc(input bit st, input logic [5:0] d, input bit b);
    start = st; data = d; bs = b;
    @(posedge clk);
    model_step(st, d, b);
    #1;
    check_all();
  endtask

  initial begin : main
    logic [5:0] pat, tmp, badv;
    int k, hold, cnt, seg, e_p, b_p;
    bit b;

    // Reset held across edges
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bsenb", 32'(bsenb), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_slipcnt", 32'(slipcnt), 0);
    chk("rst_losscnt", 32'(losscnt), 0);
    rst = 1'b0;
    cyc(0, FRAME_PAT, 0);
    chk("idle_no_bsenb", 32'(bsenb), 0);

    // 1: clean frame locks after exactly 64 samples
    cyc(1, FRAME_PAT, 0);
    chk("t1_bsenb_after_start", 32'(bsenb), 1);
    repeat (GOOD - 1) cyc(0, FRAME_PAT, 0);
    chk("t1_not_locked_63", 32'(locked), 0);
    cyc(0, FRAME_PAT, 0);
    chk("t1_locked_64", 32'(locked), 1);
    chk("t1_bsenb_off", 32'(bsenb), 0);
    chk("t1_slipcnt", 32'(slipcnt), 0);
    chk("t1_err", 32'(err), 0);

    // 2: misaligned frame rotated by a bitslip emulation until it matches
    for (int att = 0; att < 2; att++) begin
      pat = (att == 0) ? 6'b110001 : FRAME_PAT;
      if (att == 1) begin
        for (int r = 0; r < int'($urandom_range(1, 5)); r++) pat = rol6(pat);
      end
      k = 0;
      tmp = pat;
      for (int r = 0; r < 6; r++) begin
        if (tmp == FRAME_PAT && k == 0) k = r;
        tmp = rol6(tmp);
      end
      cyc(1, pat, 0);
      hold = 16;
      for (int c = 0; c < 400 && m_mode != MD_LOCK; c++) begin
        b = (hold == 0) && (m_mode == MD_SEARCH) && (pat != FRAME_PAT);
        cyc(0, pat, b);
        if (b) begin
          pat = rol6(pat);
          hold = 16;
        end else if (hold > 0) begin
          hold--;
        end
      end
      chk("t2_locked", 32'(locked), 1);
      chk("t2_slipcnt", 32'(slipcnt), 32'(k));
    end

    // BS while locked is ignored
    cyc(0, FRAME_PAT, 1);
    cyc(0, FRAME_PAT, 1);
    chk("t3_bs_ignored", 32'(slipcnt), 32'(k));

    // 3: three bad samples tolerated, four drop lock
    badv = FRAME_PAT ^ 6'($urandom_range(1, 63));
    repeat (3) cyc(0, badv, 0);
    cyc(0, FRAME_PAT, 0);
    chk("t3_still_locked", 32'(locked), 1);
    repeat (3) cyc(0, badv, 0);
    chk("t3_locked_at_3", 32'(locked), 1);
    cyc(0, badv, 0);
    chk("t3_lost", 32'(locked), 0);
    chk("t3_losscnt", 32'(losscnt), 1);
    chk("t3_bsenb", 32'(bsenb), 1);
    chk("t3_slipcnt", 32'(slipcnt), 0);

    // 4: slip exhaustion, retry delay, START clears ERR
    cyc(1, 6'b000000, 0);
    hold = 16;
    for (int c = 0; c < 400 && !m_err; c++) begin
      b = (hold == 0) && (m_mode == MD_SEARCH);
      cyc(0, 6'b000000, b);
      if (b) hold = 15;
      else if (hold > 0) hold--;
    end
    chk("t4_err", 32'(err), 1);
    chk("t4_bsenb_off", 32'(bsenb), 0);
    chk("t4_slipcnt", 32'(slipcnt), SLIPS);
    cnt = 0;
    while (!bsenb && cnt < 1100) begin
      cyc(0, 6'b000000, 0);
      cnt++;
    end
    chk("t4_retry_cycles", 32'(cnt), RETRY);
    chk("t4_err_sticky", 32'(err), 1);
    chk("t4_slip_cleared", 32'(slipcnt), 0);
    cyc(1, 6'b000000, 0);
    chk("t4_start_clears_err", 32'(err), 0);

    // 5: asynchronous reset mid-search with five slips
    repeat (5) begin
      cyc(0, 6'b000000, 1);
      cyc(0, 6'b000000, 0);
    end
    chk("t5_slipcnt", 32'(slipcnt), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_bsenb", 32'(bsenb), 0);
    chk("t5_async_slipcnt", 32'(slipcnt), 0);
    chk("t5_async_losscnt", 32'(losscnt), 0);
    chk("t5_async_err", 32'(err), 0);
    chk("t5_async_locked", 32'(locked), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // 6: START beats a simultaneous BS; START while locked keeps LOSSCNT
    cyc(1, FRAME_PAT, 0);
    repeat (30) cyc(0, FRAME_PAT, 0);
    cyc(1, FRAME_PAT, 1);
    chk("t6_slip_zero", 32'(slipcnt), 0);
    chk("t6_bsenb", 32'(bsenb), 1);
    repeat (GOOD - 1) cyc(0, FRAME_PAT, 0);
    chk("t6_not_locked_63", 32'(locked), 0);
    cyc(0, FRAME_PAT, 0);
    chk("t6_locked", 32'(locked), 1);
    cyc(1, FRAME_PAT, 0);
    chk("t6_start_unlocks", 32'(locked), 0);
    chk("t6_losscnt_kept", 32'(losscnt), 0);
    chk("t6_bsenb_restart", 32'(bsenb), 1);

    // Randomized soak in segments of varying noise and slip density
    for (seg = 0; seg < 8; seg++) begin
      case ($urandom_range(0, 3))
        0:       begin e_p = 0;  b_p = 0;  end
        1:       begin e_p = 2;  b_p = 0;  end
        2:       begin e_p = 40; b_p = 1;  end
        default: begin e_p = 5;  b_p = 10; end
      endcase
      for (int c = 0; c < 300; c++) begin
        cyc($urandom_range(0, 499) == 0,
            ($urandom_range(0, 99) < e_p) ? 6'($urandom) : FRAME_PAT,
            $urandom_range(0, 99) < b_p);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
